// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: picks one of four requesters and drives the select pair {s1,s0} of a
// 4:1 mux datapath with the winning index. A grant is held until the consumer acks, the
// requester drops, or HOLD_MAX valid cycles have passed. The last case is a forced
// release and is flagged by a one-cycle timeout pulse. All outputs are registered.
// There is always one idle cycle between two grants.
//
// Optional feature macro: RR_PRIORITY_EN
//   defined   : rotating priority. The search starts at the index after the last winner.
//   undefined : fixed priority. req[0] is highest and req[3] is lowest.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_req[3:0] request per mux input
//   i_ack      consumer accepted the current selection (sampled only while o_valid=1)
//   o_s0/o_s1  mux select, index = {o_s1,o_s0}; held through the idle gap
//   o_grant    one-hot grant, zero when not valid
//   o_valid    selection is live
//   o_timeout  one-cycle pulse after a forced (HOLD_MAX) release
module mux_sel_sequencer #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  input  logic       i_ack,
  output logic       o_s0,
  output logic       o_s1,
  output logic [3:0] o_grant,
  output logic       o_valid,
  output logic       o_timeout
);

  localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [1:0]       r_last, w_last_d;
  logic [1:0]       r_sel, w_sel_d;
  logic [3:0]       r_grant, w_grant_d;
  logic             r_valid, w_valid_d;
  logic             r_timeout, w_timeout_d;

  logic [1:0]       w_win;
  logic             w_any_req;
  logic             w_req_w;
  logic             w_hold_end;
  logic             w_release;
  logic             w_timeout_rel;

  assign w_any_req     = |i_req;
  assign w_req_w       = i_req[r_sel];
  assign w_hold_end    = (r_cnt == CNT_W'(HOLD_MAX - 1));
  assign w_release     = i_ack | ~w_req_w | w_hold_end;
  // A forced release only counts as a timeout when nothing else ended the grant.
  assign w_timeout_rel = w_hold_end & ~i_ack & w_req_w;

  // Winner search over the current request vector.
`ifdef RR_PRIORITY_EN
  always_comb begin
    logic [1:0] idx;
    logic       found;
    w_win = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = r_last + 2'(k);
      if (!found && i_req[idx]) begin
        w_win = idx;
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_win = 2'd0;
    // Descending scan so the lowest set index is the last one written.
    for (int k = 3; k >= 0; k--) begin
      if (i_req[k]) w_win = 2'(k);
    end
  end
`endif

  // State register and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_last    <= 2'd3;
      r_sel     <= 2'd0;
      r_grant   <= 4'b0000;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_last    <= w_last_d;
      r_sel     <= w_sel_d;
      r_grant   <= w_grant_d;
      r_valid   <= w_valid_d;
      r_timeout <= w_timeout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_any_req) w_state_d = StGrant;
      StGrant: if (w_release) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and bookkeeping.
  always_comb begin
    w_cnt_d     = '0;
    w_last_d    = r_last;
    w_sel_d     = r_sel;
    w_grant_d   = 4'b0000;
    w_valid_d   = 1'b0;
    w_timeout_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_valid_d = 1'b1;
          w_grant_d = 4'b0001 << w_win;
          w_sel_d   = w_win;
        end
      end
      StGrant: begin
        if (w_release) begin
          // Select stays on the old winner so the mux output is stable in the gap.
          w_last_d    = r_sel;
          w_timeout_d = w_timeout_rel;
        end else begin
          w_valid_d = 1'b1;
          w_grant_d = r_grant;
          w_cnt_d   = r_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_s0      = r_sel[0];
  assign o_s1      = r_sel[1];
  assign o_grant   = r_grant;
  assign o_valid   = r_valid;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
module tb_mux_sel_sequencer;

  localparam int HOLD = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic       o_s0, o_s1, o_valid, o_timeout;
  logic [3:0] o_grant;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 0;

  mux_sel_sequencer #(.HOLD_MAX(HOLD)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_req    (req),
    .i_ack    (ack),
    .o_s0     (o_s0),
    .o_s1     (o_s1),
    .o_grant  (o_grant),
    .o_valid  (o_valid),
    .o_timeout(o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a grant is a window of at most HOLD valid cycles for one index.
  bit         m_busy;
  int         m_held;  // valid cycles already shown for the current grant
  int         m_w;
  int         m_last;
  int         m_sel;
  bit         m_to;

  function automatic int pick(input logic [3:0] r, input int last);
    int idx;
`ifdef RR_PRIORITY_EN
    for (int k = 1; k <= 4; k++) begin
      idx = (last + k) % 4;
      if (r[idx]) return idx;
    end
`else
    for (int k = 0; k < 4; k++) begin
      idx = k;
      if (r[idx]) return idx;
    end
`endif
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_held = 0; m_w = 0; m_last = 3; m_sel = 0; m_to = 0;
    end else if (!m_busy) begin
      m_to = 0;
      if (req != 4'b0000) begin
        m_w = pick(req, m_last); m_sel = m_w; m_busy = 1; m_held = 1;
      end
    end else begin
      m_to = 0;
      if (ack || !req[m_w] || m_held == HOLD) begin
        m_to   = !ack && req[m_w];
        m_busy = 0;
        m_last = m_w;
      end else begin
        m_held++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_valid",   {7'b0, o_valid},   {7'b0, m_busy});
      chk("model_grant",   {4'b0, o_grant},   m_busy ? 8'(1 << m_w) : 8'h00);
      chk("model_sel",     {6'b0, o_s1, o_s0}, 8'(m_sel));
      chk("model_timeout", {7'b0, o_timeout}, {7'b0, m_to});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; ack = 1'b0;
    step();
    rst = 1'b0;
  endtask

  logic [3:0] seq [5];
  logic [3:0] exp_seq [5];
  int n;

  initial begin
    rst = 1'b0; req = 4'b1111; ack = 1'b0;
    // 1: reset clears outputs without a clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_async_valid", {7'b0, o_valid}, 8'h00);
    chk("rst_async_grant", {4'b0, o_grant}, 8'h00);
    chk("rst_async_sel",   {6'b0, o_s1, o_s0}, 8'h00);
    chk("rst_async_to",    {7'b0, o_timeout}, 8'h00);
    chk_en = 1;
    repeat (3) begin
      step();
      chk("rst_held_valid", {4'b0, o_grant, 3'b0, o_valid}, 8'h00);
    end
    rst = 1'b0; req = 4'b0000;
    step();

    // 2: single request, ack release keeps select
    req = 4'b0100;
    step();
    chk("t2_grant", {4'b0, o_grant}, 8'h04);
    chk("t2_sel",   {6'b0, o_s1, o_s0}, 8'h02);
    ack = 1'b1;
    step();
    chk("t2_rel_valid", {7'b0, o_valid}, 8'h00);
    chk("t2_rel_sel",   {6'b0, o_s1, o_s0}, 8'h02);
    ack = 1'b0; req = 4'b0000;
    step();

    // 3: all requesting, ack every valid cycle
    do_reset();
    req = 4'b1111;
    n = 0;
`ifdef RR_PRIORITY_EN
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    for (int i = 0; i < 20 && n < 5; i++) begin
      step();
      if (o_valid) begin
        seq[n] = o_grant;
        n++;
      end
      ack = o_valid;
    end
    ack = 1'b0;
    chk("t3_count", 8'(n), 8'd5);
    for (int i = 0; i < 5; i++) chk("t3_grant", {4'b0, seq[i]}, {4'b0, exp_seq[i]});

    // 4: hold timeout
    do_reset();
    req = 4'b0010;
    step();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!o_valid) break;
      n++;
      step();
    end
    chk("t4_valid_cycles", 8'(n), 8'd8);
    chk("t4_timeout",      {7'b0, o_timeout}, 8'h01);
    step();
    chk("t4_regrant",      {4'b0, o_grant}, 8'h02);
    chk("t4_regrant_to",   {7'b0, o_timeout}, 8'h00);

    // 5a: ack on the 8th valid cycle is a normal release
    do_reset();
    req = 4'b0010;
    step();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!o_valid) break;
      n++;
      ack = (n == 8);
      step();
    end
    ack = 1'b0;
    chk("t5a_valid_cycles", 8'(n), 8'd8);
    chk("t5a_timeout",      {7'b0, o_timeout}, 8'h00);

    // 5b: requester drops on cycle 3
    do_reset();
    req = 4'b0010;
    step();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!o_valid) break;
      n++;
      if (n == 3) req = 4'b0000;
      step();
    end
    chk("t5b_valid_cycles", 8'(n), 8'd3);
    chk("t5b_timeout",      {7'b0, o_timeout}, 8'h00);

    // 6: reset mid-grant, then fresh search starts at index 0
    do_reset();
    req = 4'b1000;
    step();
    chk("t6_grant", {4'b0, o_grant}, 8'h08);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_clear", {4'b0, o_grant, 1'b0, o_s1, o_s0, o_valid}, 8'h00);
    step();
    rst = 1'b0; req = 4'b1001;
    step();
    chk("t6_regrant", {4'b0, o_grant}, 8'h01);
    chk("t6_sel",     {6'b0, o_s1, o_s0}, 8'h00);
    req = 4'b0000;
    step();
    step();

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
